// File: rtl/ksa_sub_pipe.sv
// Pipelined Kogge-Stone subtractor: d = a - b - bin computed as a + ~b + ~bin,
// with one register per prefix level and a single global stall enable.
module ksa_sub_pipe #(
    parameter int BITS   = 64,
    parameter int LEVELS = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [BITS-1:0] a,
    input  logic [BITS-1:0] b,
    input  logic            bin,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [BITS-1:0] d,
    output logic            bout,
    output logic            ov,
    output logic            out_valid,
    input  logic            out_ready
);

    // Handshake: a transfer happens on a rising edge where valid & ready are
    // both high; the whole pipe moves only when the output slot is empty or
    // being taken, so in_ready is that same enable (no bubble compression).
    logic            w_en;

    logic [BITS-1:0] w_p_in;
    logic [BITS-1:0] w_g_in;
    logic [BITS-1:0] w_p_nx [1:LEVELS];
    logic [BITS-1:0] w_g_nx [1:LEVELS];
    logic [BITS-1:0] w_d;

    // Index 0 is the operand stage, index k the result of prefix level k.
    logic [BITS-1:0] r_p    [0:LEVELS];
    logic [BITS-1:0] r_g    [0:LEVELS];
    logic [BITS-1:0] r_p0   [0:LEVELS];
    logic            r_cin  [0:LEVELS];
    logic            r_amsb [0:LEVELS];
    logic            r_bmsb [0:LEVELS];
    logic [LEVELS:0] r_vld;

    logic [BITS-1:0] r_d;
    logic            r_bout;
    logic            r_ov;
    logic            r_ovld;

    assign w_en      = ~r_ovld | out_ready;
    assign in_ready  = w_en;
    assign d         = r_d;
    assign bout      = r_bout;
    assign ov        = r_ov;
    assign out_valid = r_ovld;

    // Carry-in ~bin is folded into G[0] so the tree needs no separate cin path.
    always_comb begin
        w_p_in    = a ^ ~b;
        w_g_in    = a & ~b;
        w_g_in[0] = (a[0] & ~b[0]) | (w_p_in[0] & ~bin);
    end

    always_comb begin
        for (int k = 1; k <= LEVELS; k++) begin
            w_p_nx[k] = r_p[k-1];
            w_g_nx[k] = r_g[k-1];
            for (int i = (1 << (k - 1)); i < BITS; i++) begin
                w_p_nx[k][i] = r_p[k-1][i] & r_p[k-1][i-(1 << (k - 1))];
                w_g_nx[k][i] = r_g[k-1][i] | (r_p[k-1][i] & r_g[k-1][i-(1 << (k - 1))]);
            end
        end
    end

    // Sum bit i uses the carry into bit i: cin for bit 0, Gfinal[i-1] above.
    assign w_d = r_p0[LEVELS] ^ {r_g[LEVELS][BITS-2:0], r_cin[LEVELS]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k <= LEVELS; k++) begin
                r_p[k]    <= '0;
                r_g[k]    <= '0;
                r_p0[k]   <= '0;
                r_cin[k]  <= 1'b0;
                r_amsb[k] <= 1'b0;
                r_bmsb[k] <= 1'b0;
            end
            r_vld  <= '0;
            r_d    <= '0;
            r_bout <= 1'b0;
            r_ov   <= 1'b0;
            r_ovld <= 1'b0;
        end else if (w_en) begin
            r_p[0]    <= w_p_in;
            r_g[0]    <= w_g_in;
            r_p0[0]   <= w_p_in;
            r_cin[0]  <= ~bin;
            r_amsb[0] <= a[BITS-1];
            r_bmsb[0] <= b[BITS-1];
            for (int k = 1; k <= LEVELS; k++) begin
                r_p[k]    <= w_p_nx[k];
                r_g[k]    <= w_g_nx[k];
                r_p0[k]   <= r_p0[k-1];
                r_cin[k]  <= r_cin[k-1];
                r_amsb[k] <= r_amsb[k-1];
                r_bmsb[k] <= r_bmsb[k-1];
            end
            r_vld  <= {r_vld[LEVELS-1:0], in_valid};
            r_d    <= w_d;
            r_bout <= ~r_g[LEVELS][BITS-1];
            r_ov   <= (r_amsb[LEVELS] ^ r_bmsb[LEVELS]) & (r_amsb[LEVELS] ^ w_d[BITS-1]);
            r_ovld <= r_vld[LEVELS];
        end
    end

endmodule
